serial_sub8: RTL and testbench
==============================

# serial_sub8

Bit-serial 8-bit two's-complement subtractor with a start/done handshake. It computes a − b − bin one bit per clock through a single full-subtractor cell. It is the sequential, subtract-direction counterpart to the team's parallel 8-bit adders, and sits beside them in the arithmetic datapath. Outputs are held stable between operations, so a host FSM or FPGA demo can sample them at leisure.

## Interface
Parameters:
- none (width fixed at 8)

Ports:
- clk  input  1  single system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only when idle
- a  input  8  minuend; captured on accepted start
- b  input  8  subtrahend; captured on accepted start
- bin  input  1  borrow-in; captured on accepted start
- diff  output  8  result a − b − bin (mod 256)
- bout  output  1  final borrow-out; 1 when unsigned a < b + bin
- ovf  output  1  signed overflow
- zero  output  1  diff == 0
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse

## Operation
- FSM with two states, IDLE and RUN; reset state is IDLE.
- IDLE with start=1 at an edge:
  - Load shift registers A←a and B←b.
  - Load the borrow register br←bin.
  - Clear the bit counter cnt (3 bits).
  - Go to RUN.
- RUN performs one step per edge on the LSBs A[0], B[0] and br:
  - d = A[0]^B[0]^br
  - br_next = (~A[0]&B[0]) | (~(A[0]^B[0])&br)
  - A and B shift right.
  - d shifts into the result register R from the MSB end.
  - cnt increments.
- On the step where cnt==7:
  - Go to IDLE.
  - Copy the completed result into diff.
  - bout ← br_next.
  - zero ← (completed result == 0).
  - ovf ← (a7 != b7) && (result7 != a7), using the captured a7 and b7.
  - Pulse done.
- diff, bout, ovf and zero change only at completion. Partial results are never visible on them. They hold until the next completion or reset.
- start while in RUN is ignored. No queueing, and the captured operands are not disturbed.
- a, b and bin may change freely after the accepting edge.
- Arithmetic is modulo 2^8. bin=1 subtracts one extra.

## Timing
- Reset values: diff=0x00, bout=0, ovf=0, zero=0, busy=0, done=0, state IDLE.
- Accepting edge E0 (start=1 in IDLE):
  - busy=1 from E0.
  - Bit i is produced at edge E(i+1), i=0..7.
- At E8:
  - diff, bout, ovf and zero are updated.
  - done=1 for exactly one cycle (E8 to E9).
  - busy=0.
- Latency is 8 clocks from the accepting edge to done.
- Back-to-back operation: start=1 during the done cycle is accepted at E9. The next done comes at E17, so throughput is one result per 9 cycles minimum.
- start held continuously high restarts at every idle edge. Previous results stay visible until the next completion.
- rst asserted mid-RUN (at any time) immediately aborts:
  - All outputs and state go to reset values.
  - No done is generated.
  - After rst deasserts, start is accepted normally.
- busy and done are never both 1.

## Test plan
- Basic subtract: a=0x50, b=0x20, bin=0, start pulse.
  - Expected: done exactly 8 edges later; diff=0x30, bout=0, ovf=0, zero=0.
- Borrow out: a=0x20, b=0x50, bin=0.
  - Expected: diff=0xD0, bout=1, ovf=0.
- Signed overflow, case 1: a=0x80, b=0x01.
  - Expected: diff=0x7F, ovf=1, bout=0.
- Signed overflow, case 2: a=0x7F, b=0xFF.
  - Expected: diff=0x80, ovf=1, bout=1.
- Borrow-in and zero:
  - a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1, zero=0.
  - a=0x7F, b=0x7F, bin=0 → diff=0x00, zero=1.
- Handshake:
  - Start a job; pulse start with different operands at E3 → ignored, result matches the first operands.
  - Raise start during the done cycle → second done 9 cycles after the first.
  - Check diff stays stable between dones.
- Reset mid-op: assert rst after E4.
  - Expected: outputs go to 0 immediately and no done is produced.
  - Then a new operation 0x05−0x03 completes with diff=0x02.

Source files
------------

// File: rtl/serial_sub8.sv
// serial_sub8: bit-serial 8-bit subtractor computing a - b - bin, one bit per clock, with start/done handshake
module serial_sub8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic [7:0] diff,
  output logic       bout,
  output logic       ovf,
  output logic       zero,
  output logic       busy,
  output logic       done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, nxt;
  logic [7:0] sa, sb, r, res;
  logic [2:0] cnt;
  logic br, a7, b7, d, br_n, last;
  assign d    = sa[0] ^ sb[0] ^ br;
  assign br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign res  = {d, r[7:1]};
  assign busy = state == RUN;
  assign last = busy && cnt == 3'd7;
  always_comb nxt = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;
  // operand MSBs are kept separately because the shift registers lose them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa <= '0; sb <= '0; r <= '0; cnt <= '0; br <= 1'b0; a7 <= 1'b0; b7 <= 1'b0;
      diff <= '0; bout <= 1'b0; ovf <= 1'b0; zero <= 1'b0; done <= 1'b0;
    end else begin
      done <= last;
      if (state == IDLE && start) begin
        sa <= a; sb <= b; br <= bin; cnt <= '0; a7 <= a[7]; b7 <= b[7];
      end else if (busy) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        r   <= res;
        br  <= br_n;
        cnt <= cnt + 3'd1;
        if (last) begin
          diff <= res;
          bout <= br_n;
          zero <= res == 8'h00;
          ovf  <= (a7 != b7) && (res[7] != a7);
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_sub8.sv
// tb_serial_sub8: directed checks of serial_sub8 results, handshake timing and mid-operation reset
module tb_serial_sub8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, bin = 1'b0;
  logic [7:0] a = '0, b = '0, diff;
  logic bout, ovf, zero, busy, done;
  int checks = 0, errors = 0;

  serial_sub8 dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
                   .diff(diff), .bout(bout), .ovf(ovf), .zero(zero), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    step();
    start = 1'b0; a = 8'hAA; b = 8'h55; bin = ~tbin;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
  endtask

  task automatic finish_op(input string tag, input logic [7:0] ed, input logic eb,
                           input logic eo, input logic ez, input logic [7:0] hold);
    for (int i = 1; i < 8; i++) begin
      step();
      chk({tag, "_nodone"}, done, 0);
      chk({tag, "_hold"}, diff, hold);
    end
    step();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_zero"}, zero, ez);
  endtask

  task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                    input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
    logic [7:0] hold;
    hold = diff;
    launch(ta, tb, tbin);
    finish_op(tag, ed, eb, eo, ez, hold);
    step();
    chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    step();
    step();
    chk("rst_diff", diff, 8'h00);
    chk("rst_flags", {bout, ovf, zero, busy, done}, 0);
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    op("basic",   8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
    op("borrow",  8'h20, 8'h50, 1'b0, 8'hD0, 1'b1, 1'b0, 1'b0);
    op("ovf1",    8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    op("ovf2",    8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
    op("binzero", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    op("zero",    8'h7F, 8'h7F, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // start during RUN is ignored; start in the done cycle begins the next job
    launch(8'h10, 8'h03, 1'b0);
    step(); step();
    a = 8'hF0; b = 8'h01; bin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_busy", busy, 1);
    for (int i = 4; i < 8; i++) begin
      step();
      chk("ign_nodone", done, 0);
      chk("ign_hold", diff, 8'h00);
    end
    step();
    chk("ign_done", done, 1);
    chk("ign_diff", diff, 8'h0D);
    chk("ign_bout", bout, 0);
    a = 8'h09; b = 8'h04; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    finish_op("b2b", 8'h05, 1'b0, 1'b0, 1'b0, 8'h0D);

    step();
    launch(8'h50, 8'h20, 1'b0);
    step(); step(); step(); step();
    rst = 1'b1;
    #1;
    chk("abort_diff", diff, 8'h00);
    chk("abort_flags", {bout, ovf, zero, busy, done}, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("abort_nodone", done, 0);
    end
    rst = 1'b0;
    step();
    op("after_rst", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
